// File: rtl/sum_acc_pkg.sv
// Shared constants and width helper for the windowed sum accumulator.
// Imported by the accumulator so callers and the block agree on sample and total widths.
package sum_acc_pkg;

    localparam int unsigned SUM_W          = 9;
    localparam int unsigned DEFAULT_WINDOW = 4;
    localparam int unsigned MAX_WINDOW     = 16;

    // Width that holds WINDOW full-scale samples without wrap.
    function automatic int unsigned acc_width(input int unsigned window);
        return SUM_W + $clog2(window);
    endfunction

endpackage

// File: rtl/sum_window_accumulator.sv
// Accumulates WINDOW adder sums and emits total and peak per window through a
// single-entry registered output slot, back-pressuring only the final sample of a window.
module sum_window_accumulator
    import sum_acc_pkg::*;
#(
    parameter int unsigned WINDOW = DEFAULT_WINDOW,
    parameter int unsigned ACC_W  = acc_width(MAX_WINDOW)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [SUM_W-1:0] out_peak
);

    localparam int unsigned CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

    if (WINDOW < 2 || WINDOW > MAX_WINDOW) begin : gen_bad_window
        $error("sum_window_accumulator: WINDOW must be within 2..16");
    end
    if (ACC_W < acc_width(WINDOW)) begin : gen_bad_acc_w
        $error("sum_window_accumulator: ACC_W too narrow for WINDOW full-scale samples");
    end

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] peak_q, peak_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic [SUM_W-1:0] out_peak_q, out_peak_d;

    logic             last;
    logic             accept;
    logic [ACC_W-1:0] acc_sum;
    logic [SUM_W-1:0] peak_new;

    assign last     = (cnt_q == CNT_LAST);
    // Only the closing sample needs the slot, so earlier samples never stall.
    assign in_ready = !clr && !(last && out_valid_q && !out_ready);
    assign accept   = in_valid && in_ready;
    assign acc_sum  = acc_q + ACC_W'(in_data);
    assign peak_new = (in_data > peak_q) ? in_data : peak_q;

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        peak_d      = peak_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_peak_d  = out_peak_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (clr) begin
            acc_d  = '0;
            cnt_d  = '0;
            peak_d = '0;
        end else if (accept) begin
            if (last) begin
                // A reload in the draining cycle overrides the clear above.
                out_valid_d = 1'b1;
                out_data_d  = acc_sum;
                out_peak_d  = peak_new;
                acc_d       = '0;
                cnt_d       = '0;
                peak_d      = '0;
            end else begin
                acc_d  = acc_sum;
                peak_d = peak_new;
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            peak_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_peak_q  <= '0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            peak_q      <= peak_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_peak_q  <= out_peak_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_peak  = out_peak_q;

endmodule

// File: tb/tb_sum_window_accumulator.sv
// Directed and scoreboard bench for sum_window_accumulator at WINDOW=4 and WINDOW=16.
module tb_sum_window_accumulator;
    import sum_acc_pkg::*;

    localparam int unsigned ACC_W = 13;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clr = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [SUM_W-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [ACC_W-1:0] out_data;
    logic [SUM_W-1:0] out_peak;

    logic             in_valid16 = 1'b0;
    logic             in_ready16;
    logic [SUM_W-1:0] in_data16 = '0;
    logic             out_valid16;
    logic [ACC_W-1:0] out_data16;
    logic [SUM_W-1:0] out_peak16;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sum_window_accumulator #(.WINDOW(4), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_peak  (out_peak)
    );

    sum_window_accumulator #(.WINDOW(16), .ACC_W(ACC_W)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .clr       (1'b0),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .in_data   (in_data16),
        .out_valid (out_valid16),
        .out_ready (1'b1),
        .out_data  (out_data16),
        .out_peak  (out_peak16)
    );

    // Inputs change 1ns after the rising edge; outputs are sampled before the next one.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int d);
        in_valid = v;
        in_data  = SUM_W'(d);
    endtask

    task automatic test_reset();
        #2;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        n_vec++;
        if (out_data !== 13'd0 || out_peak !== 9'd0) begin
            n_err++; $display("FAIL reset_out_data got %0d/%0d want 0/0", out_data, out_peak);
        end
        n_vec++;
        if (out_valid16 !== 1'b0 || in_ready16 !== 1'b1) begin
            n_err++; $display("FAIL reset_dut16 got v=%b r=%b want 0/1", out_valid16, in_ready16);
        end
        #10;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int vals[4] = '{10, 20, 30, 40};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, vals[i]);
            #1;
            n_vec++;
            if (in_ready !== 1'b1) begin
                n_err++; $display("FAIL basic_ready[%0d] got %b want 1", i, in_ready);
            end
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++; $display("FAIL basic_early_valid[%0d] got %b want 0", i, out_valid);
            end
            tick();
        end
        drive(1'b0, 0);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 13'd100 || out_peak !== 9'd40) begin
            n_err++;
            $display("FAIL basic_window got v=%b d=%0d p=%0d want 1/100/40",
                     out_valid, out_data, out_peak);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL basic_drain got %b want 0", out_valid);
        end
    endtask

    task automatic test_full_scale();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 510);
            tick();
        end
        drive(1'b0, 0);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 13'd2040 || out_peak !== 9'd510) begin
            n_err++;
            $display("FAIL max4 got v=%b d=%0d p=%0d want 1/2040/510",
                     out_valid, out_data, out_peak);
        end
        tick();
        for (int i = 0; i < 16; i++) begin
            in_valid16 = 1'b1;
            in_data16  = 9'd510;
            tick();
        end
        in_valid16 = 1'b0;
        n_vec++;
        if (out_valid16 !== 1'b1 || out_data16 !== 13'd8160 || out_peak16 !== 9'd510) begin
            n_err++;
            $display("FAIL max16 got v=%b d=%0d p=%0d want 1/8160/510",
                     out_valid16, out_data16, out_peak16);
        end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1);
            #1;
            n_vec++;
            if (in_ready !== 1'b1) begin
                n_err++; $display("FAIL bp_ready[%0d] got %b want 1", i, in_ready);
            end
            tick();
            if (i == 3) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_data !== 13'd4 || out_peak !== 9'd1) begin
                    n_err++;
                    $display("FAIL bp_first got v=%b d=%0d p=%0d want 1/4/1",
                             out_valid, out_data, out_peak);
                end
            end
        end
        drive(1'b1, 1);
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL bp_stall got %b want 0", in_ready);
        end
        tick();
        n_vec++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 13'd4) begin
            n_err++;
            $display("FAIL bp_hold got r=%b v=%b d=%0d want 0/1/4", in_ready, out_valid, out_data);
        end
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_release got %b want 1", in_ready);
        end
        tick();
        drive(1'b0, 0);
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 13'd4 || out_peak !== 9'd1) begin
            n_err++;
            $display("FAIL bp_reload got v=%b d=%0d p=%0d want 1/4/1",
                     out_valid, out_data, out_peak);
        end
        out_ready = 1'b1;
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL bp_drain got %b want 0", out_valid);
        end
    endtask

    task automatic test_clr();
        int vals[4] = '{1, 2, 3, 4};
        out_ready = 1'b1;
        drive(1'b1, 5); tick();
        drive(1'b1, 6); tick();
        clr = 1'b1;
        drive(1'b1, 100);
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL clr_ready got %b want 0", in_ready);
        end
        tick();
        clr = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, vals[i]);
            tick();
        end
        drive(1'b0, 0);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 13'd10 || out_peak !== 9'd4) begin
            n_err++;
            $display("FAIL clr_window got v=%b d=%0d p=%0d want 1/10/4",
                     out_valid, out_data, out_peak);
        end
        // A clr must not disturb a pending slot draining in the same cycle.
        clr = 1'b1;
        out_ready = 1'b1;
        tick();
        clr = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL clr_drain got %b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 9);
            tick();
        end
        drive(1'b0, 0);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 13'd36) begin
            n_err++; $display("FAIL rstmid_pending got v=%b d=%0d want 1/36", out_valid, out_data);
        end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 13'd0 || out_peak !== 9'd0) begin
            n_err++;
            $display("FAIL rstmid_async got v=%b d=%0d p=%0d want 0/0/0",
                     out_valid, out_data, out_peak);
        end
        rst = 1'b0;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 7);
            tick();
        end
        drive(1'b0, 0);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 13'd28 || out_peak !== 9'd7) begin
            n_err++;
            $display("FAIL rstmid_after got v=%b d=%0d p=%0d want 1/28/7",
                     out_valid, out_data, out_peak);
        end
        tick();
    endtask

    task automatic test_random();
        int          m_cnt = 0;
        int          m_acc = 0;
        int          m_peak = 0;
        logic        m_ov = 1'b0;
        int          m_od = 0;
        int          m_op = 0;
        int          d;
        logic        v;
        logic        exp_ready;
        int          windows = 0;
        out_ready = 1'b1;
        drive(1'b0, 0);
        tick();
        for (int c = 0; c < 300; c++) begin
            v = ($urandom_range(0, 3) != 0);
            d = $urandom_range(0, 510);
            out_ready = ($urandom_range(0, 2) != 0);
            drive(v, d);
            #1;
            exp_ready = !(m_cnt == 3 && m_ov && !out_ready);
            n_vec++;
            if (in_ready !== exp_ready || out_valid !== m_ov) begin
                n_err++;
                $display("FAIL rand_hs[%0d] got r=%b v=%b want r=%b v=%b",
                         c, in_ready, out_valid, exp_ready, m_ov);
            end
            if (m_ov) begin
                n_vec++;
                if (out_data !== ACC_W'(m_od) || out_peak !== SUM_W'(m_op)) begin
                    n_err++;
                    $display("FAIL rand_slot[%0d] got d=%0d p=%0d want d=%0d p=%0d",
                             c, out_data, out_peak, m_od, m_op);
                end
            end
            if (m_ov && out_ready) m_ov = 1'b0;
            if (v && exp_ready) begin
                m_acc  += d;
                m_peak = (d > m_peak) ? d : m_peak;
                if (m_cnt == 3) begin
                    m_ov = 1'b1; m_od = m_acc; m_op = m_peak;
                    m_acc = 0; m_peak = 0; m_cnt = 0;
                    windows++;
                end else begin
                    m_cnt++;
                end
            end
            tick();
        end
        drive(1'b0, 0);
        n_vec++;
        if (windows < 20) begin
            n_err++; $display("FAIL rand_windows got %0d want >=20", windows);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_scale();
        test_backpressure();
        test_clr();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
